gf180mcu_fd_sc_mcu9t5v0_dist3_seq: RTL and testbench

//  1-to-3 sequential bit distributor. The inverse direction of a 3-input reduction gate.
//  - Accepts one bit per valid/ready transfer on D.
//  - Steers successive bits round-robin into lanes 1..3.
//  - Presents each completed triple on registered Q1..Q3 with a valid/ready handshake.
//  - Sits upstream of 3-input cells (nor3 and similar) in the library's sequential test/macro fabric.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0_dist3_seq.sv | 117 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0_dist3_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_dist3_seq.sv
// 1-to-3 sequential bit distributor: serial D bits are gathered into registered triples Q1..Q3.
// Optional GF180MCU_DIST3_NORCHK_EN adds a registered ZN = ~(Q1|Q2|Q3) output.
module gf180mcu_fd_sc_mcu9t5v0_dist3_seq #(
    parameter int ORDER = 0,
    parameter int TMO   = 15,
    parameter int TMO_W = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    input  logic DV,
    output logic DR,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic QV,
    input  logic QR,
    output logic PART,
`ifdef GF180MCU_DIST3_NORCHK_EN
    output logic ZN,
`endif
    inout  wire  VDD,
    inout  wire  VSS
);

    // Handshakes: a transfer happens on a rising CLK edge where valid & ready are both 1;
    // valid must stay asserted with stable data until that edge, ready may depend on the sink state.

    localparam logic [TMO_W-1:0] TMO_LAST = (TMO > 0) ? TMO_W'(TMO - 1) : '0;

    logic [1:0]       l_q, l_d;
    logic [1:0]       buf_q, buf_d;
    logic [2:0]       q_q, q_d;
    logic             qv_q, qv_d;
    logic             part_q, part_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             accept, consume, complete;
    logic             unused_supply;

    assign unused_supply = VDD ^ VSS;

    // Only the completing bit can stall: it needs the output register free this cycle.
    assign DR   = !((l_q == 2'd2) && qv_q && !QR);
    assign Q1   = q_q[2];
    assign Q2   = q_q[1];
    assign Q3   = q_q[0];
    assign QV   = qv_q;
    assign PART = part_q;

    always_comb begin
        l_d      = l_q;
        buf_d    = buf_q;
        q_d      = q_q;
        qv_d     = qv_q;
        tmo_d    = tmo_q;
        accept   = DV && DR;
        consume  = qv_q && QR;
        complete = accept && (l_q == 2'd2);

        if (accept) begin
            if (l_q == 2'd0) buf_d[0] = D;
            if (l_q == 2'd1) buf_d[1] = D;
            l_d   = complete ? 2'd0 : l_q + 2'd1;
            tmo_d = '0;
        end else if ((l_q != 2'd0) && (TMO > 0)) begin
            if (tmo_q == TMO_LAST) begin
                l_d   = 2'd0;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end

        // A completion overrides a same-cycle consume so the output never bubbles.
        if (complete) begin
            q_d  = (ORDER == 0) ? {buf_q[0], buf_q[1], D} : {D, buf_q[1], buf_q[0]};
            qv_d = 1'b1;
        end else if (consume) begin
            qv_d = 1'b0;
        end

        part_d = (l_d != 2'd0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            l_q    <= 2'd0;
            buf_q  <= 2'd0;
            q_q    <= 3'd0;
            qv_q   <= 1'b0;
            part_q <= 1'b0;
            tmo_q  <= '0;
        end else begin
            l_q    <= l_d;
            buf_q  <= buf_d;
            q_q    <= q_d;
            qv_q   <= qv_d;
            part_q <= part_d;
            tmo_q  <= tmo_d;
        end
    end

`ifdef GF180MCU_DIST3_NORCHK_EN
    logic zn_q, zn_d;

    assign zn_d = ~|q_d;
    assign ZN   = zn_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) zn_q <= 1'b1;
        else     zn_q <= zn_d;
    end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_dist3_seq.sv
// Bench for the 1-to-3 distributor: ORDER=0 and ORDER=1 instances share stimulus,
// a negedge model predicts DR/QV/PART and queues expected triples for comparison on consume.
module tb_gf180mcu_fd_sc_mcu9t5v0_dist3_seq;

    localparam int TMO_T = 3;

    logic clk, rst, d, dv, qr;
    logic dr0, q1_0, q2_0, q3_0, qv0, part0;
    logic dr1, q1_1, q2_1, q3_1, qv1, part1;
`ifdef GF180MCU_DIST3_NORCHK_EN
    logic zn0, zn1;
`endif
    wire  vdd_n, vss_n;
    assign vdd_n = 1'b1;
    assign vss_n = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] exp_q[$];
    int         ml, mtmo;
    logic [1:0] mbuf;
    logic       mqv, mdr, macc, mcons, mcomp;
    logic [2:0] e;

    gf180mcu_fd_sc_mcu9t5v0_dist3_seq #(.ORDER(0), .TMO(TMO_T), .TMO_W(4)) dut0 (
        .CLK(clk), .RST(rst), .D(d), .DV(dv), .DR(dr0),
        .Q1(q1_0), .Q2(q2_0), .Q3(q3_0), .QV(qv0), .QR(qr), .PART(part0),
`ifdef GF180MCU_DIST3_NORCHK_EN
        .ZN(zn0),
`endif
        .VDD(vdd_n), .VSS(vss_n)
    );

    gf180mcu_fd_sc_mcu9t5v0_dist3_seq #(.ORDER(1), .TMO(TMO_T), .TMO_W(4)) dut1 (
        .CLK(clk), .RST(rst), .D(d), .DV(dv), .DR(dr1),
        .Q1(q1_1), .Q2(q2_1), .Q3(q3_1), .QV(qv1), .QR(qr), .PART(part1),
`ifdef GF180MCU_DIST3_NORCHK_EN
        .ZN(zn1),
`endif
        .VDD(vdd_n), .VSS(vss_n)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        logic got;
        got = 1'b0;
        dv  = 1'b1;
        d   = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = dr0;
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        repeat (n) cyc();
    endtask

    // Scoreboard / model, evaluated at negedge for the upcoming rising edge
    always @(negedge clk) begin
        if (rst) begin
            ml = 0; mtmo = 0; mbuf = 2'b00; mqv = 1'b0;
            exp_q.delete();
        end else begin
            mdr = !(ml == 2 && mqv && !qr);
            check("dr_o0", dr0, mdr);
            check("dr_o1", dr1, mdr);
            check("qv_o0", qv0, mqv);
            check("qv_o1", qv1, mqv);
            check("part_o0", part0, ml != 0);
            check("part_o1", part1, ml != 0);
`ifdef GF180MCU_DIST3_NORCHK_EN
            check("zn_o0", zn0, ~(q1_0 | q2_0 | q3_0));
            check("zn_o1", zn1, ~(q1_1 | q2_1 | q3_1));
`endif
            macc  = dv && mdr;
            mcons = mqv && qr;
            mcomp = macc && (ml == 2);
            if (mcons) begin
                if (exp_q.size() == 0) begin
                    check("pop_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("q_o0", {q1_0, q2_0, q3_0}, e);
                    check("q_o1", {q1_1, q2_1, q3_1}, {e[0], e[1], e[2]});
                end
            end
            if (macc) begin
                if (ml == 2) begin
                    exp_q.push_back({mbuf[0], mbuf[1], d});
                    ml = 0;
                end else begin
                    mbuf[ml] = d;
                    ml++;
                end
                mtmo = 0;
            end else if (ml != 0) begin
                if (mtmo == TMO_T - 1) begin
                    ml = 0;
                    mtmo = 0;
                end else begin
                    mtmo++;
                end
            end else begin
                mtmo = 0;
            end
            if (mcomp) mqv = 1'b1;
            else if (mcons) mqv = 1'b0;
        end
    end

    initial begin
        rst = 1'b0; d = 1'b0; dv = 1'b0; qr = 1'b0;
        // async reset asserted between edges
        #2 rst = 1'b1;
        #1;
        check("rst_q", {q1_0, q2_0, q3_0}, 3'b000);
        check("rst_qv", qv0, 0);
        check("rst_part", part0, 0);
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        check("rst_dr", dr0, 1);

        // back-to-back triples, QR held high
        qr = 1'b1;
        send_bit(1); send_bit(0); send_bit(1);
        dv = 1'b0;
        check("t2_qv", qv0, 1);
        check("t2_q_o0", {q1_0, q2_0, q3_0}, 3'b101);
        cyc();
        check("t2_qv_drop", qv0, 0);
        check("t2_dr", dr0, 1);
        send_bit(1); send_bit(1); send_bit(0);
        dv = 1'b0;
        check("t2_q_o1", {q1_1, q2_1, q3_1}, 3'b011);
        check("t2_q_o0b", {q1_0, q2_0, q3_0}, 3'b110);
        cyc();

        // backpressure
        qr = 1'b0;
        send_bit(0); send_bit(0); send_bit(0);
        send_bit(1); send_bit(1);
        d = 1'b1; dv = 1'b1;
        #1;
        check("bp_dr_low", dr0, 0);
        check("bp_part", part0, 1);
        cyc(); cyc();
        check("bp_dr_still_low", dr0, 0);
        qr = 1'b1;
        #1;
        check("bp_dr_freed", dr0, 1);
        cyc();
        qr = 1'b0; dv = 1'b0;
        check("bp_no_bubble", qv0, 1);
        check("bp_q_new", {q1_0, q2_0, q3_0}, 3'b111);
        qr = 1'b1;
        cyc(); cyc();

        // timeout discards a partial triple
        send_bit(1); send_bit(0);
        idle(2);
        check("tmo_part_hold", part0, 1);
        cyc();
        check("tmo_part_clear", part0, 0);
        send_bit(1); send_bit(1); send_bit(0);
        idle(2);

        // accept on the timeout cycle wins
        send_bit(0); send_bit(1);
        idle(2);
        send_bit(1);
        dv = 1'b0;
        check("race_q", {q1_0, q2_0, q3_0}, 3'b011);
        check("race_qv", qv0, 1);
        cyc(); cyc();

        // random traffic honouring the hold rule
        for (int i = 0; i < 300; i++) begin
            logic acc;
            @(negedge clk);
            acc = dv && dr0;
            @(posedge clk);
            #1;
            if (!dv || acc) begin
                dv = 1'($urandom_range(0, 1));
                d  = 1'($urandom_range(0, 1));
            end
            qr = 1'($urandom_range(0, 3) != 0);
        end
        dv = 1'b0; qr = 1'b1;
        idle(6);

        // reset mid-operation with a pending triple and a partial one
        qr = 1'b0;
        send_bit(1); send_bit(0); send_bit(0); send_bit(1);
        dv = 1'b0;
        check("r6_pre_qv", qv0, 1);
        check("r6_pre_part", part0, 1);
        #2 rst = 1'b1;
        #1;
        check("r6_qv", qv0, 0);
        check("r6_part", part0, 0);
        check("r6_q", {q1_0, q2_0, q3_0}, 3'b000);
`ifdef GF180MCU_DIST3_NORCHK_EN
        check("r6_zn", zn0, 1);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        check("r6_dr", dr0, 1);
        qr = 1'b1;
        send_bit(0); send_bit(1); send_bit(1);
        dv = 1'b0;
        check("r6_fresh", {q1_0, q2_0, q3_0}, 3'b011);
        idle(4);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
